// File: rtl/control_register_pkg.sv
// Shared constants for the MCDF control register file: command codes, register map, CTRL field layout.
package control_register_pkg;

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_RD   = 2'b01;
  localparam logic [1:0] CMD_WR   = 2'b10;

  localparam int ADDR_CTRL0 = 'h00;
  localparam int ADDR_CTRL1 = 'h04;
  localparam int ADDR_CTRL2 = 'h08;
  localparam int ADDR_STAT0 = 'h10;
  localparam int ADDR_STAT1 = 'h14;
  localparam int ADDR_STAT2 = 'h18;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_PRIO_LSB   = 1;
  localparam int CTRL_PKGLEN_LSB = 3;
  localparam int CTRL_W          = 6;

  localparam logic [31:0] CTRL_RST = 32'h0000_0007;

endpackage

// File: rtl/control_register_if.sv
// Single-cycle command bus (idle/read/write) between a host and the control register file.
interface control_register_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic [1:0]            cmd_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [DATA_WIDTH-1:0] cmd_data_i;
  logic [DATA_WIDTH-1:0] cmd_data_o;

  modport master (
    output cmd_i, cmd_addr_i, cmd_data_i,
    input  cmd_data_o
  );

  modport slave (
    input  cmd_i, cmd_addr_i, cmd_data_i,
    output cmd_data_o
  );
endinterface

// File: rtl/control_register_slv_ctrl_reg.sv
// One per-channel CTRL register (en/prio/pkglen); fields are live on the outputs right after the write edge.
module slv_ctrl_reg
  import control_register_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [CTRL_W-1:0]     wr_data_i,
  output logic                  en_o,
  output logic [1:0]            prio_o,
  output logic [2:0]            pkglen_o,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam logic [CTRL_W-1:0] RST_VAL = CTRL_W'(CTRL_RST);

  logic [CTRL_W-1:0] ctrl_d;
  logic [CTRL_W-1:0] ctrl_q;

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_en_i) begin
      ctrl_d = wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q <= RST_VAL;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  // Reserved bits are not stored, so the read value is zero-extended.
  assign en_o      = ctrl_q[CTRL_EN_BIT];
  assign prio_o    = ctrl_q[CTRL_PRIO_LSB +: 2];
  assign pkglen_o  = ctrl_q[CTRL_PKGLEN_LSB +: 3];
  assign rd_data_o = DATA_WIDTH'(ctrl_q);

endmodule

// File: rtl/control_register.sv
// MCDF register file: 3 R/W CTRL regs + 3 RO STAT regs (STAT only with CR_STATUS_REG_EN), one-cycle read latency.
// Writes take effect at the edge; no stall or handshake, a command may be issued every cycle.
module control_register
  import control_register_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 6,
  parameter int MARGIN_WIDTH = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  control_register_if.slave       bus,
  input  logic [MARGIN_WIDTH-1:0] slv0_margin_i,
  input  logic [MARGIN_WIDTH-1:0] slv1_margin_i,
  input  logic [MARGIN_WIDTH-1:0] slv2_margin_i,
  output logic                    slv0_en_o,
  output logic                    slv1_en_o,
  output logic                    slv2_en_o,
  output logic [1:0]              slv0_prio_o,
  output logic [1:0]              slv1_prio_o,
  output logic [1:0]              slv2_prio_o,
  output logic [2:0]              slv0_pkglen_o,
  output logic [2:0]              slv1_pkglen_o,
  output logic [2:0]              slv2_pkglen_o
);

  localparam logic [ADDR_WIDTH-1:0] A_CTRL0 = ADDR_WIDTH'(ADDR_CTRL0);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL1 = ADDR_WIDTH'(ADDR_CTRL1);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL2 = ADDR_WIDTH'(ADDR_CTRL2);
`ifdef CR_STATUS_REG_EN
  localparam logic [ADDR_WIDTH-1:0] A_STAT0 = ADDR_WIDTH'(ADDR_STAT0);
  localparam logic [ADDR_WIDTH-1:0] A_STAT1 = ADDR_WIDTH'(ADDR_STAT1);
  localparam logic [ADDR_WIDTH-1:0] A_STAT2 = ADDR_WIDTH'(ADDR_STAT2);
`endif

  logic [2:0]            wr_en;
  logic [DATA_WIDTH-1:0] ctrl0_rd;
  logic [DATA_WIDTH-1:0] ctrl1_rd;
  logic [DATA_WIDTH-1:0] ctrl2_rd;
  logic [DATA_WIDTH-1:0] cmd_data_d;
  logic [DATA_WIDTH-1:0] cmd_data_q;

  // Reserved write-data bits are deliberately dropped.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^bus.cmd_data_i[DATA_WIDTH-1:CTRL_W];

`ifndef CR_STATUS_REG_EN
  logic unused_margins;
  assign unused_margins = ^{slv0_margin_i, slv1_margin_i, slv2_margin_i};
`endif

  always_comb begin
    wr_en = '0;
    if (bus.cmd_i == CMD_WR) begin
      wr_en[0] = (bus.cmd_addr_i == A_CTRL0);
      wr_en[1] = (bus.cmd_addr_i == A_CTRL1);
      wr_en[2] = (bus.cmd_addr_i == A_CTRL2);
    end
  end

  // Idle, write and the 2'b11 code all clear the read data, so it is valid for one cycle only.
  always_comb begin
    cmd_data_d = '0;
    if (bus.cmd_i == CMD_RD) begin
      case (bus.cmd_addr_i)
        A_CTRL0: cmd_data_d = ctrl0_rd;
        A_CTRL1: cmd_data_d = ctrl1_rd;
        A_CTRL2: cmd_data_d = ctrl2_rd;
`ifdef CR_STATUS_REG_EN
        A_STAT0: cmd_data_d = DATA_WIDTH'(slv0_margin_i);
        A_STAT1: cmd_data_d = DATA_WIDTH'(slv1_margin_i);
        A_STAT2: cmd_data_d = DATA_WIDTH'(slv2_margin_i);
`endif
        default: cmd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd_data_q <= '0;
    end else begin
      cmd_data_q <= cmd_data_d;
    end
  end

  assign bus.cmd_data_o = cmd_data_q;

  slv_ctrl_reg #(.DATA_WIDTH(DATA_WIDTH)) u_ctrl0 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en[0]),
    .wr_data_i (bus.cmd_data_i[CTRL_W-1:0]),
    .en_o      (slv0_en_o),
    .prio_o    (slv0_prio_o),
    .pkglen_o  (slv0_pkglen_o),
    .rd_data_o (ctrl0_rd)
  );

  slv_ctrl_reg #(.DATA_WIDTH(DATA_WIDTH)) u_ctrl1 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en[1]),
    .wr_data_i (bus.cmd_data_i[CTRL_W-1:0]),
    .en_o      (slv1_en_o),
    .prio_o    (slv1_prio_o),
    .pkglen_o  (slv1_pkglen_o),
    .rd_data_o (ctrl1_rd)
  );

  slv_ctrl_reg #(.DATA_WIDTH(DATA_WIDTH)) u_ctrl2 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en[2]),
    .wr_data_i (bus.cmd_data_i[CTRL_W-1:0]),
    .en_o      (slv2_en_o),
    .prio_o    (slv2_prio_o),
    .pkglen_o  (slv2_pkglen_o),
    .rd_data_o (ctrl2_rd)
  );

endmodule

// File: tb/tb_control_register.sv
// Scoreboard bench for control_register: directed map/reset cases followed by random commands.
module tb_control_register;

  logic       clk;
  logic       rst;
  logic [5:0] m0, m1, m2;
  logic       en0, en1, en2;
  logic [1:0] pr0, pr1, pr2;
  logic [2:0] pl0, pl1, pl2;

  control_register_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) bus ();

  control_register #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .MARGIN_WIDTH(6)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bus           (bus),
    .slv0_margin_i (m0),
    .slv1_margin_i (m1),
    .slv2_margin_i (m2),
    .slv0_en_o     (en0),
    .slv1_en_o     (en1),
    .slv2_en_o     (en2),
    .slv0_prio_o   (pr0),
    .slv1_prio_o   (pr1),
    .slv2_prio_o   (pr2),
    .slv0_pkglen_o (pl0),
    .slv1_pkglen_o (pl1),
    .slv2_pkglen_o (pl2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic [17:0] outs;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference state: the six stored bits of each CTRL register, as a plain array.
  logic [5:0] ctrl_m [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [17:0] dut_outs();
    return {pl2, pr2, en2, pl1, pr1, en1, pl0, pr0, en0};
  endfunction

  function automatic logic [17:0] model_outs();
    logic [17:0] r;
    for (int i = 0; i < 3; i++) begin
      // en is bit 0, prio bits 2:1, pkglen bits 5:3 of each register
      r[i*6 +: 6] = {ctrl_m[i][5:3], ctrl_m[i][2:1], ctrl_m[i][0]};
    end
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int addr);
    logic [5:0] mg [3];
    mg[0] = m0; mg[1] = m1; mg[2] = m2;
    if (addr % 4 != 0) return 32'h0;
    if (addr < 12) return {26'h0, ctrl_m[addr / 4]};
`ifdef CR_STATUS_REG_EN
    if (addr >= 16 && addr <= 24) return {26'h0, mg[(addr - 16) / 4]};
`endif
    return 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) ctrl_m[i] = 6'd7;
  endtask

  // Drive one command for the coming edge and queue the response expected just after it.
  task automatic issue(input logic [1:0] c, input int addr, input logic [31:0] d, input string tag);
    exp_t e;
    @(negedge clk);
    bus.cmd_i      = c;
    bus.cmd_addr_i = 6'(addr);
    bus.cmd_data_i = d;
    e.rd = (c == 2'b01) ? model_read(addr) : 32'h0;
    if (c == 2'b10 && addr % 4 == 0 && addr < 12) ctrl_m[addr / 4] = d[5:0];
    e.outs = model_outs();
    e.tag  = tag;
    sbq.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check({e.tag, "_rdata"}, bus.cmd_data_o, e.rd);
        check({e.tag, "_outs"}, {14'h0, dut_outs()}, {14'h0, e.outs});
      end
    end
  end

  initial begin : driver
    int addrs [7];
    int a;
    addrs = '{'h00, 'h04, 'h08, 'h0C, 'h10, 'h14, 'h18};

    rst = 1'b1;
    bus.cmd_i = 2'b00; bus.cmd_addr_i = '0; bus.cmd_data_i = '0;
    m0 = 6'd0; m1 = 6'd0; m2 = 6'd0;
    model_reset();
    #27;
    rst = 1'b0;
    #1;
    check("reset_outs", {14'h0, dut_outs()}, {14'h0, model_outs()});
    check("reset_rdata", bus.cmd_data_o, 32'h0);

    issue(2'b10, 'h00, 32'hD1, "wr_ctrl0");
    issue(2'b10, 'h04, 32'hD2, "wr_ctrl1");
    issue(2'b10, 'h08, 32'hD3, "wr_ctrl2");
    issue(2'b01, 'h04, 32'h0,  "rd_ctrl1");
    issue(2'b10, 'h00, 32'hD4, "rewr_ctrl0");
    issue(2'b01, 'h00, 32'h0,  "rd_ctrl0");
    issue(2'b00, 'h00, 32'h0,  "idle_after_rd");

    m0 = 6'd21; m1 = 6'd33; m2 = 6'd45;
    issue(2'b01, 'h10, 32'h0, "rd_stat0");
    issue(2'b01, 'h14, 32'h0, "rd_stat1");
    issue(2'b01, 'h18, 32'h0, "rd_stat2");

    issue(2'b10, 'h10, 32'hFF, "wr_stat0");
    issue(2'b10, 'h0C, 32'hFF, "wr_unmapped");
    issue(2'b01, 'h0C, 32'h0,  "rd_unmapped");
    issue(2'b01, 'h05, 32'h0,  "rd_misaligned");
    issue(2'b11, 'h00, 32'h0,  "cmd11");
    issue(2'b10, 'h08, 32'h3F, "wr_pkglen7");
    issue(2'b01, 'h08, 32'h0,  "rd_pkglen7");

    // Asynchronous reset between edges while read data is being presented.
    issue(2'b10, 'h04, 32'h2A, "wr_before_rst");
    issue(2'b01, 'h04, 32'h0,  "rd_before_rst");
    @(posedge clk);
    #3;
    check("sb_empty_before_rst", sbq.size(), 0);
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_outs", {14'h0, dut_outs()}, {14'h0, model_outs()});
    check("async_rst_rdata", bus.cmd_data_o, 32'h0);
    @(negedge clk);
    bus.cmd_i = 2'b00;
    rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      m0 = 6'($urandom); m1 = 6'($urandom); m2 = 6'($urandom);
      a = ($urandom_range(0, 7) < 7) ? addrs[$urandom_range(0, 6)] : int'($urandom_range(0, 63));
      issue(2'($urandom_range(0, 3)), a, $urandom, "rand");
    end

    issue(2'b00, 'h00, 32'h0, "final_idle");
    for (int k = 0; k < 20 && sbq.size() > 0; k++) @(posedge clk);
    #2;
    check("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
